// File: rtl/fetch_if.sv
// Fetch stage bundle: redirect, imem request/response channel and decode handshake.
// perf_bubbles_o exists only when FETCH_PERF_EN is defined.
interface fetch_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [AWIDTH-1:0] imem_req_addr_o;
    logic              imem_rsp_valid_i;
    logic [DWIDTH-1:0] imem_rsp_data_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_bubbles_o;
`endif

    modport master (
`ifdef FETCH_PERF_EN
        output perf_bubbles_o,
`endif
        input  redirect_i, redirect_pc_i, imem_req_ready_i,
        input  imem_rsp_valid_i, imem_rsp_data_i, ready_i,
        output imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, insn_o
    );

    modport slave (
`ifdef FETCH_PERF_EN
        input  perf_bubbles_o,
`endif
        output redirect_i, redirect_pc_i, imem_req_ready_i,
        output imem_rsp_valid_i, imem_rsp_data_i, ready_i,
        input  imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, insn_o
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: PC, in-flight address queue, {pc,insn} FIFO and redirect flush.
// Define FETCH_PERF_EN to add the perf_bubbles_o decode-starvation counter.
module fetch #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int                DEPTH    = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] aq [DEPTH];
    logic [PW-1:0]     aq_wr, aq_rd;
    logic [AWIDTH-1:0] fq_pc   [DEPTH];
    logic [DWIDTH-1:0] fq_insn [DEPTH];
    logic [PW-1:0]     fq_wr, fq_rd;
    logic [CW-1:0]     fcnt, outst, drop, outst_nx;
    logic [CW:0]       credit;
    logic              acc, rsp, push, pop;

    // Credits cover both in-flight words and buffered words, so the FIFO can never overflow.
    assign credit               = {1'b0, outst} + {1'b0, fcnt};
    assign bus.imem_req_valid_o = !rst && (credit < (CW+1)'(DEPTH));
    assign bus.imem_req_addr_o  = pc_q;
    assign acc                  = bus.imem_req_valid_o && bus.imem_req_ready_i;
    assign rsp                  = bus.imem_rsp_valid_i && (outst != '0);
    assign push                 = rsp && (drop == '0) && !bus.redirect_i;
    assign pop                  = bus.valid_o && bus.ready_i && !bus.redirect_i;
    assign outst_nx             = outst + CW'(acc) - CW'(rsp);

    assign bus.valid_o = (fcnt != '0);
    assign bus.pc_o    = fq_pc[fq_rd];
    assign bus.insn_o  = fq_insn[fq_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= BASEADDR;
            outst <= '0;
            drop  <= '0;
            aq_wr <= '0;
            aq_rd <= '0;
            fq_wr <= '0;
            fq_rd <= '0;
            fcnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aq[i]      <= '0;
                fq_pc[i]   <= '0;
                fq_insn[i] <= '0;
            end
        end else begin
            if (bus.redirect_i)
                pc_q <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            else if (acc)
                pc_q <= pc_q + AWIDTH'(4);

            // The address queue survives a redirect so stale responses still pop in order.
            if (acc) begin
                aq[aq_wr] <= pc_q;
                aq_wr     <= aq_wr + PW'(1);
            end
            if (rsp)
                aq_rd <= aq_rd + PW'(1);

            outst <= outst_nx;
            if (bus.redirect_i)
                drop <= outst_nx;
            else if (rsp && (drop != '0))
                drop <= drop - CW'(1);

            if (bus.redirect_i) begin
                fq_wr <= '0;
                fq_rd <= '0;
                fcnt  <= '0;
            end else begin
                if (push) begin
                    fq_pc[fq_wr]   <= aq[aq_rd];
                    fq_insn[fq_wr] <= bus.imem_rsp_data_i;
                    fq_wr          <= fq_wr + PW'(1);
                end
                if (pop)
                    fq_rd <= fq_rd + PW'(1);
                if (push && !pop)
                    fcnt <= fcnt + CW'(1);
                else if (pop && !push)
                    fcnt <= fcnt - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubbles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubbles <= '0;
        else if (bus.ready_i && !bus.valid_o)
            bubbles <= bubbles + 32'd1;
    end

    assign bus.perf_bubbles_o = bubbles;
`endif
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a sequential-PC program model feeds an expected queue,
// a separate monitor checks every word delivered to decode.
`timescale 1ns/1ps
module tb_fetch;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
  fetch #(.DWIDTH(DW), .AWIDTH(AW), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct { int t; logic [31:0] d; } mrsp_t;

  ent_t        exp_q[$];
  mrsp_t       mem_q[$];
  logic [31:0] next_pc = BASE;
  logic [31:0] bub_model = 32'd0;
  int cyc = 0, last_t = 0, lat_lo = 1, lat_hi = 1;
  int compared = 0, mismatched = 0;
  int n_acc = 0, first_acc = -1, first_vld = -1, rc = 0;
  bit last_redir = 1'b0;

  // Instruction memory contents: an arbitrary fixed function of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus. rmode: 0 none, 1 redirect, 2 redirect only when an
  // accept and a decode pop both happen this cycle.
  task automatic cycle(input int rmode, input logic [31:0] tgt, input bit rdy, input bit mrdy);
    bit redir;
    int t;
    @(negedge clk);
    cyc++;
    redir = (rmode == 1) || (rmode == 2 && bus.valid_o && bus.imem_req_valid_o);
    last_redir           = redir;
    bus.redirect_i       = redir;
    bus.redirect_pc_i    = tgt;
    bus.ready_i          = rdy;
    bus.imem_req_ready_i = mrdy;
    if (mem_q.size() != 0 && mem_q[0].t <= cyc) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = mem_q[0].d;
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = $urandom;
    end
    #1;
    if (bus.valid_o && first_vld < 0) first_vld = cyc;
    if (rdy && !bus.valid_o) bub_model = bub_model + 32'd1;
    if (bus.imem_rsp_valid_i) void'(mem_q.pop_front());
    if (bus.imem_req_valid_o && mrdy) begin
      check("req_addr", bus.imem_req_addr_o, next_pc);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      t = cyc + $urandom_range(lat_hi, lat_lo);
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      mem_q.push_back('{t, memword(bus.imem_req_addr_o)});
      if (!redir) exp_q.push_back('{next_pc, memword(next_pc)});
      next_pc = next_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      next_pc   = {tgt[31:2], 2'b00};
      first_vld = -1;
    end
  endtask

  // Reset pulse; responses still owed for pre-reset requests arrive right after release
  // while nothing new is accepted, so the DUT must ignore them.
  task automatic do_reset();
    int n;
    @(negedge clk);
    cyc++;
    rst                  = 1'b1;
    bus.redirect_i       = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.ready_i          = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    #1;
    check("rst_req_valid", bus.imem_req_valid_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_pc", bus.pc_o, 0);
    check("rst_insn", bus.insn_o, 0);
    repeat (2) begin @(negedge clk); cyc++; end
    n = mem_q.size();
    foreach (mem_q[i]) mem_q[i].t = cyc + 1 + i;
    last_t    = cyc + n;
    exp_q.delete();
    next_pc   = BASE;
    bub_model = 32'd0;
    first_acc = -1;
    first_vld = -1;
    rst = 1'b0;
    #1;
    check("first_req_valid", bus.imem_req_valid_o, 1);
    check("first_req_addr", bus.imem_req_addr_o, BASE);
    repeat (n) cycle(0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every decode handshake pops the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.valid_o && bus.ready_i && !bus.redirect_i) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_out: got pc %0h insn %0h expected no word", bus.pc_o, bus.insn_o);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", bus.pc_o, e.pc);
          check("out_insn", bus.insn_o, e.insn);
        end
      end
    end
  end

  initial begin
    int n0, r;
    logic [31:0] tgt;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.ready_i          = 1'b0;

    // Streaming from reset with 1-cycle memory.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (12) cycle(0, 32'd0, 1'b1, 1'b1);
    check("lat_req_to_valid", first_vld - first_acc, 2);

    // Redirect latency with 1-cycle memory.
    cycle(1, 32'h0100_0040, 1'b1, 1'b1);
    rc = cyc;
    repeat (6) cycle(0, 32'd0, 1'b1, 1'b1);
    check("redir_to_valid", first_vld - rc, 3);

    // Decode stall: credits cap issue, then drain in order.
    n0 = n_acc;
    repeat (5) cycle(0, 32'd0, 1'b0, 1'b1);
    check("stall_accepts_le_depth", ((n_acc - n0) <= DEPTH), 1);
    check("stall_req_valid", bus.imem_req_valid_o, 0);
    repeat (10) cycle(0, 32'd0, 1'b1, 1'b1);

    // Two in flight on 3-cycle memory, redirect to an unaligned target.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) cycle(0, 32'd0, 1'b0, 1'b1);
    cycle(1, 32'h0100_0103, 1'b1, 1'b1);
    repeat (14) cycle(0, 32'd0, 1'b1, 1'b1);

    // Redirect coinciding with an accept and a pop.
    lat_lo = 1; lat_hi = 1;
    repeat (4) cycle(0, 32'd0, 1'b1, 1'b1);
    last_redir = 1'b0;
    for (int i = 0; i < 20 && !last_redir; i++) cycle(2, 32'h0100_0200, 1'b1, 1'b1);
    check("redir_acc_pop_hit", last_redir, 1);
    repeat (10) cycle(0, 32'd0, 1'b1, 1'b1);

    // Reset with one request outstanding; its late response must be ignored.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    cycle(0, 32'd0, 1'b1, 1'b1);
    cycle(0, 32'd0, 1'b1, 1'b0);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (10) cycle(0, 32'd0, 1'b1, 1'b1);

    // PC wrap-around at the top of the address space.
    cycle(1, 32'hFFFF_FFFA, 1'b1, 1'b1);
    repeat (10) cycle(0, 32'd0, 1'b1, 1'b1);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(999);
      if (r < 3) begin
        do_reset();
      end else begin
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        cycle((r < 40) ? 1 : 0, tgt, ($urandom_range(3) != 0), ($urandom_range(3) != 0));
      end
    end

    // Drain: every expected word must come out.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle(0, 32'd0, 1'b1, 1'b0);
    check("drain_empty", exp_q.size(), 0);
    cycle(0, 32'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf_bubbles", bus.perf_bubbles_o, bub_model);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
